ysyx_22050598_ifu_fetch: RTL and testbench

YSYX_22050598_IFU_FETCH -- requirements
Module: ysyx_22050598_ifu_fetch

---
 rtl/ysyx_22050598_ifu_fetch.sv | 142 ++++++++++++++
 tb/tb_ysyx_22050598_ifu_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_ifu_fetch.sv
// Instruction fetch unit: PC register, single-outstanding imem request FSM, and instruction hand-off to ID.
// Latency: instruction is presented to ID one cycle after ifu_rsp_valid; at most one request is in flight.
// Backpressure: ifu_req_addr is held while ifu_req_ready=0; the fetched instruction is held in HOLD while if_ready=0.
//
// Optional feature macro: YSYX_22050598_IFU_BPU_EN
//   defined   -> next PC = pc + bpu_pc_add_op when prdt_taken, else pc + 4
//   undefined -> next PC = pc + 4, if_prdt_taken tied low, predictor inputs ignored
//
// Ports:
//   clk, rst                       core clock, asynchronous active-high reset
//   ifu_req_valid/ready/addr       instruction memory request channel (addr = PC)
//   ifu_rsp_valid/inst             instruction memory response, one pulse per accepted request
//   bpu_inst, bpu_pc_add_op,       static predictor: instruction out, offset and taken flag in
//   prdt_taken
//   if_valid/ready, if_pc,         fetched instruction hand-off to ID
//   if_inst, if_prdt_taken
//   ex_flush, ex_flush_pc          redirect from EXU
module ysyx_22050598_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [63:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_inst,
  output logic [31:0] bpu_inst,
  input  logic [63:0] bpu_pc_add_op,
  input  logic        prdt_taken,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_prdt_taken,
  input  logic        ex_flush,
  input  logic [63:0] ex_flush_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;   // a flushed request's response is still on its way back
  logic [63:0] pc_next;          // sequential or predicted successor of pc_q
  logic        use_pred;

`ifdef YSYX_22050598_IFU_BPU_EN
  assign use_pred = prdt_taken;
  assign pc_next  = pc_q + (prdt_taken ? bpu_pc_add_op : 64'd4);
`else
  logic unused_bpu;
  assign unused_bpu = ^{bpu_pc_add_op, prdt_taken};
  assign use_pred   = 1'b0;
  assign pc_next    = pc_q + 64'd4;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    drop_d        = drop_q;
    ifu_req_valid = 1'b0;
    if_valid      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (ex_flush) pc_d = ex_flush_pc;
      end

      S_REQ: begin
        ifu_req_valid = 1'b1;
        if (ex_flush) pc_d = ex_flush_pc;
        if (ifu_req_ready) begin
          state_d = S_WAIT;
          // Request went out with the old PC in the same cycle as the
          // redirect: its response must be thrown away.
          if (ex_flush) drop_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (ex_flush) pc_d = ex_flush_pc;
        if (ifu_rsp_valid) begin
          if (drop_q || ex_flush) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = ifu_rsp_inst;
            state_d = S_HOLD;
          end
        end else if (ex_flush) begin
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if_valid = ~drop_q;
        // Redirect wins over the predicted successor.
        if (ex_flush) begin
          pc_d    = ex_flush_pc;
          state_d = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_next;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  assign ifu_req_addr  = pc_q;
  assign bpu_inst      = inst_q;
  assign if_pc         = pc_q;
  assign if_inst       = inst_q;
  assign if_prdt_taken = (state_q == S_HOLD) && use_pred;

endmodule

// File: tb/tb_ysyx_22050598_ifu_fetch.sv
module tb_ysyx_22050598_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
`ifdef YSYX_22050598_IFU_BPU_EN
  localparam bit BPU_ON = 1'b1;
`else
  localparam bit BPU_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic [63:0] ifu_req_addr;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = 32'h0;
  logic [31:0] bpu_inst;
  logic [63:0] bpu_pc_add_op = 64'h0;
  logic        prdt_taken = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        if_prdt_taken;
  logic        ex_flush = 1'b0;
  logic [63:0] ex_flush_pc = 64'h0;

  int tests = 0;
  int fails = 0;

  ysyx_22050598_ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .bpu_inst(bpu_inst), .bpu_pc_add_op(bpu_pc_add_op), .prdt_taken(prdt_taken),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_prdt_taken(if_prdt_taken), .ex_flush(ex_flush), .ex_flush_pc(ex_flush_pc)
  );

  always #5 clk = ~clk;

  // Reference successor rule: taken branches jump by the predictor offset only when the predictor is built in.
  function automatic logic [63:0] ref_next(input logic [63:0] pc, input bit taken, input logic [63:0] off);
    return (BPU_ON && taken) ? pc + off : pc + 64'd4;
  endfunction

  // Stimulus helpers (no checking inside).
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifu_req_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic accept_req();
    ifu_req_ready = 1'b1; tick(); ifu_req_ready = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] inst);
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = inst; tick(); ifu_rsp_valid = 1'b0;
  endtask

  task automatic flush_to(input logic [63:0] pc);
    ex_flush = 1'b1; ex_flush_pc = pc; tick(); ex_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; prdt_taken = 1'b1; tick(); tick();
    tests++; if (ifu_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", ifu_req_valid); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    tests++; if (if_prdt_taken !== 1'b0) begin fails++; $display("FAIL reset_prdt: got %b want 0", if_prdt_taken); end
    tests++; if (bpu_inst !== 32'h13) begin fails++; $display("FAIL reset_bpu_inst: got %h want 00000013", bpu_inst); end
    tests++; if (if_pc !== RESET_PC) begin fails++; $display("FAIL reset_pc: got %h want %h", if_pc, RESET_PC); end
    prdt_taken = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    wait_req(ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_req_timeout: got none want request"); end
    tests++; if (ifu_req_addr !== 64'h8000_0000) begin fails++; $display("FAIL basic_addr0: got %h want 80000000", ifu_req_addr); end
    accept_req();
    tests++; if (ifu_req_valid !== 1'b0) begin fails++; $display("FAIL basic_no_req_wait: got %b want 0", ifu_req_valid); end
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h13; #1;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", if_valid); end
    tick(); ifu_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL basic_if_valid: got %b want 1", if_valid); end
    tests++; if (if_pc !== 64'h8000_0000) begin fails++; $display("FAIL basic_if_pc: got %h want 80000000", if_pc); end
    tests++; if (if_inst !== 32'h13) begin fails++; $display("FAIL basic_if_inst: got %h want 00000013", if_inst); end
    if_ready = 1'b1; tick(); if_ready = 1'b0;
    wait_req(ok);
    tests++; if (!ok || ifu_req_addr !== 64'h8000_0004) begin fails++; $display("FAIL basic_addr1: got %h want 80000004", ifu_req_addr); end
  endtask

  // jal +0x20, backward beq -8, and a taken branch across the top of the address space.
  task automatic test_branch();
    logic [63:0] t_pc  [3] = '{64'h8000_0010, 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFC};
    logic [31:0] t_ins [3] = '{32'h0200_006F, 32'hFE00_0CE3, 32'h0080_0063};
    logic [63:0] t_off [3] = '{64'h20, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8};
    bit ok;
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      flush_to(t_pc[i]);
      wait_req(ok);
      tests++; if (!ok || ifu_req_addr !== t_pc[i]) begin fails++; $display("FAIL branch%0d_addr: got %h want %h", i, ifu_req_addr, t_pc[i]); end
      accept_req(); send_rsp(t_ins[i]);
      prdt_taken = 1'b1; bpu_pc_add_op = t_off[i]; #1;
      tests++; if (bpu_inst !== t_ins[i]) begin fails++; $display("FAIL branch%0d_bpu_inst: got %h want %h", i, bpu_inst, t_ins[i]); end
      tests++; if (if_prdt_taken !== BPU_ON) begin fails++; $display("FAIL branch%0d_prdt: got %b want %b", i, if_prdt_taken, BPU_ON); end
      if_ready = 1'b1; tick(); if_ready = 1'b0; prdt_taken = 1'b0;
      exp = ref_next(t_pc[i], 1'b1, t_off[i]);
      wait_req(ok);
      tests++; if (!ok || ifu_req_addr !== exp) begin fails++; $display("FAIL branch%0d_next: got %h want %h", i, ifu_req_addr, exp); end
    end
  endtask

  task automatic test_flush_wait();
    bit ok;
    accept_req(); tick();
    flush_to(64'h8000_2000);
    tests++; if (if_valid !== 1'b0 || ifu_req_valid !== 1'b0) begin fails++; $display("FAIL fw_after_flush: got v=%b r=%b want 0 0", if_valid, ifu_req_valid); end
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'hDEAD_BEEF; #1;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fw_stale_valid: got %b want 0", if_valid); end
    tick(); ifu_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fw_dropped: got %b want 0", if_valid); end
    wait_req(ok);
    tests++; if (!ok || ifu_req_addr !== 64'h8000_2000) begin fails++; $display("FAIL fw_redirect: got %h want 80002000", ifu_req_addr); end
    // flush in the same cycle the response returns
    accept_req();
    ex_flush = 1'b1; ex_flush_pc = 64'h8000_3000; ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h1234_5678;
    tick(); ex_flush = 1'b0; ifu_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fw_coincide_valid: got %b want 0", if_valid); end
    wait_req(ok);
    tests++; if (!ok || ifu_req_addr !== 64'h8000_3000) begin fails++; $display("FAIL fw_coincide_addr: got %h want 80003000", ifu_req_addr); end
  endtask

  task automatic test_hold_stall_flush();
    bit ok;
    accept_req(); send_rsp(32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (if_valid !== 1'b1 || if_pc !== 64'h8000_3000 || if_inst !== 32'h0010_0093 || ifu_req_valid !== 1'b0) begin
        fails++; $display("FAIL stall%0d: got v=%b pc=%h inst=%h req=%b want 1 80003000 00100093 0", i, if_valid, if_pc, if_inst, ifu_req_valid);
      end
      tick();
    end
    ex_flush = 1'b1; ex_flush_pc = 64'h8000_4000; if_ready = 1'b1; prdt_taken = 1'b1; bpu_pc_add_op = 64'h40;
    tick(); ex_flush = 1'b0; if_ready = 1'b0; prdt_taken = 1'b0;
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL hsf_valid: got %b want 0", if_valid); end
    wait_req(ok);
    tests++; if (!ok || ifu_req_addr !== 64'h8000_4000) begin fails++; $display("FAIL hsf_addr: got %h want 80004000", ifu_req_addr); end
  endtask

  task automatic test_random(input logic [63:0] start_pc);
    logic [63:0] model_pc = start_pc;
    logic [63:0] fp, off;
    logic [31:0] inst;
    bit ok, taken;
    for (int n = 0; n < 40; n++) begin
      wait_req(ok);
      tests++; if (!ok || ifu_req_addr !== model_pc) begin fails++; $display("FAIL rnd%0d_addr: got %h want %h", n, ifu_req_addr, model_pc); end
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        tick();
        tests++; if (ifu_req_valid !== 1'b1 || ifu_req_addr !== model_pc) begin fails++; $display("FAIL rnd%0d_req_hold: got %b %h want 1 %h", n, ifu_req_valid, ifu_req_addr, model_pc); end
      end
      accept_req();
      for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
        tests++; if (ifu_req_valid !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_wait: got r=%b v=%b want 0 0", n, ifu_req_valid, if_valid); end
        tick();
      end
      fp = {$urandom, $urandom} & ~64'd3;
      inst = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        ex_flush = 1'b1; ex_flush_pc = fp;
        if ($urandom_range(0, 1) == 1) begin
          ifu_rsp_valid = 1'b1; ifu_rsp_inst = inst; tick(); ifu_rsp_valid = 1'b0; ex_flush = 1'b0;
        end else begin
          tick(); ex_flush = 1'b0; send_rsp(inst);
        end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_drop: got %b want 0", n, if_valid); end
        model_pc = fp;
        continue;
      end
      send_rsp(inst);
      tests++; if (if_valid !== 1'b1 || if_pc !== model_pc || if_inst !== inst) begin fails++; $display("FAIL rnd%0d_hold: got %b %h %h want 1 %h %h", n, if_valid, if_pc, if_inst, model_pc, inst); end
      taken = 1'($urandom_range(0, 1));
      off = {{52{1'b0}}, 12'($urandom)} & ~64'd1;
      if ($urandom_range(0, 1) == 1) off = -off;
      prdt_taken = taken; bpu_pc_add_op = off;
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        tick();
        tests++; if (if_valid !== 1'b1 || ifu_req_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_stall: got v=%b r=%b want 1 0", n, if_valid, ifu_req_valid); end
      end
      #1;
      tests++; if (if_prdt_taken !== (BPU_ON & taken)) begin fails++; $display("FAIL rnd%0d_prdt: got %b want %b", n, if_prdt_taken, BPU_ON & taken); end
      if_ready = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        ex_flush = 1'b1; ex_flush_pc = fp; model_pc = fp;
      end else begin
        model_pc = ref_next(model_pc, taken, off);
      end
      tick(); if_ready = 1'b0; ex_flush = 1'b0; prdt_taken = 1'b0;
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    wait_req(ok);
    accept_req();
    #2 rst = 1'b1; #1;
    tests++; if (ifu_req_valid !== 1'b0 || if_valid !== 1'b0 || if_prdt_taken !== 1'b0) begin fails++; $display("FAIL rmw_ctrl: got r=%b v=%b p=%b want 0 0 0", ifu_req_valid, if_valid, if_prdt_taken); end
    tests++; if (if_pc !== RESET_PC || bpu_inst !== 32'h13) begin fails++; $display("FAIL rmw_regs: got %h %h want %h 00000013", if_pc, bpu_inst, RESET_PC); end
    tick(); rst = 1'b0;
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = 32'h0BAD_0BAD; tick(); ifu_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (if_valid !== 1'b0 || ifu_req_valid !== 1'b1 || ifu_req_addr !== RESET_PC) begin fails++; $display("FAIL rmw_stale%0d: got v=%b r=%b a=%h want 0 1 %h", i, if_valid, ifu_req_valid, ifu_req_addr, RESET_PC); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_flush_wait();
    test_hold_stall_flush();
    test_random(64'h8000_4000);
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
